// File: rtl/pixel_histogram_if.sv
// Histogram readout stream between pixel_histogram (master) and its consumer (slave).
//
// Handshake: a bin transfers on every rising clock edge where hist_valid_o and
// hist_ready_i are both high. Once hist_valid_o rises, hist_bin_o, hist_data_o
// and hist_last_o hold steady until that transfer; valid never depends on ready.
//
// Signals:
//   hist_bin_o    index of the bin on offer
//   hist_data_o   count held in that bin
//   hist_valid_o  a bin is on offer
//   hist_last_o   the bin on offer is the final one (all-ones index)
//   hist_ready_i  consumer accepts the bin on offer
interface pixel_histogram_if #(
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 24
);
    logic [BIN_BITS-1:0] hist_bin_o;
    logic [CNT_W-1:0]    hist_data_o;
    logic                hist_valid_o;
    logic                hist_last_o;
    logic                hist_ready_i;

    modport master (
        output hist_bin_o, hist_data_o, hist_valid_o, hist_last_o,
        input  hist_ready_i
    );

    modport slave (
        input  hist_bin_o, hist_data_o, hist_valid_o, hist_last_o,
        output hist_ready_i
    );
endinterface

// File: rtl/pixel_histogram.sv
// Per-frame intensity histogram of a parallel pixel stream (fv/lv/pd).
// Bins live in a single-port-write RAM. One frame is accumulated, the bins
// are streamed out in ascending order, and each bin is zeroed as it is read.
//
// Ports:
//   clk_pixel_i      pixel clock (only clock)
//   reset_i          synchronous active-high reset
//   pd_i             pixel data; bin = top BIN_BITS bits
//   fv_i, lv_i       frame valid / line valid
//   enable_i         arms capture of the next frame start
//   hist             readout stream (pixel_histogram_if.master)
//   frame_done_o     pulse on the transfer of the last bin
//   frame_dropped_o  pulse when a frame start arrives while not IDLE
//   pixel_count_o    pixels accumulated in the last captured frame
//   busy_o           high in every state except IDLE
module pixel_histogram #(
    parameter int PIX_W    = 10,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 24
) (
    input  logic                   clk_pixel_i,
    input  logic                   reset_i,
    input  logic [PIX_W-1:0]       pd_i,
    input  logic                   fv_i,
    input  logic                   lv_i,
    input  logic                   enable_i,
    pixel_histogram_if.master      hist,
    output logic                   frame_done_o,
    output logic                   frame_dropped_o,
    output logic [31:0]            pixel_count_o,
    output logic                   busy_o
);

    localparam int NBINS = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t state, state_nxt;

    logic                fv_q;
    logic                fv_rise, fv_fall;
    logic [BIN_BITS-1:0] idx;          // clear pointer in CLEAR, readout pointer in READOUT
    logic [31:0]         pix_cnt;

    logic [CNT_W-1:0]    mem [NBINS];
    logic [CNT_W-1:0]    rd_data;
    logic                we;
    logic [BIN_BITS-1:0] waddr, raddr;
    logic [CNT_W-1:0]    wdata;

    // Read-modify-write pipeline: stage 1 holds the bin whose RAM read is in
    // flight, stage 2 holds the incremented value being written this cycle,
    // stage 3 remembers the previous write, which the synchronous read
    // issued in the same cycle could not yet observe.
    logic                s1_valid, s2_valid, s3_valid;
    logic [BIN_BITS-1:0] s1_bin, s2_bin, s3_bin;
    logic [CNT_W-1:0]    s2_val, s3_val;
    logic [CNT_W-1:0]    base, inc;

    logic                pix_valid;
    logic [BIN_BITS-1:0] pix_bin;
    logic                hs;
    logic                pipe_empty;

    assign fv_rise    = fv_i & ~fv_q;
    assign fv_fall    = ~fv_i & fv_q;
    assign pix_valid  = (state == S_ACCUM) & fv_i & lv_i;
    assign pix_bin    = pd_i[PIX_W-1 -: BIN_BITS];
    assign hs         = (state == S_READOUT) & hist.hist_ready_i;
    assign pipe_empty = ~s1_valid & ~s2_valid;

    // Newest value wins: the write in progress, then the one just completed.
    assign base = (s2_valid && s2_bin == s1_bin) ? s2_val :
                  (s3_valid && s3_bin == s1_bin) ? s3_val : rd_data;
    assign inc  = (&base) ? base : base + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR:   if (idx == LAST_BIN)        state_nxt = S_IDLE;
            S_IDLE:    if (fv_rise && enable_i)    state_nxt = S_ACCUM;
            S_ACCUM:   if (fv_fall)                state_nxt = S_DRAIN;
            S_DRAIN:   if (pipe_empty)             state_nxt = S_READOUT;
            S_READOUT: if (hs && idx == LAST_BIN)  state_nxt = S_IDLE;
            default:                               state_nxt = S_CLEAR;
        endcase
    end

    // RAM port steering. In DRAIN the read address parks on bin 0, so the
    // first readout word is already on rd_data when READOUT is entered.
    always_comb begin
        we    = 1'b0;
        waddr = s2_bin;
        wdata = s2_val;
        raddr = '0;
        case (state)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = idx;
                wdata = '0;
            end
            S_READOUT: begin
                we    = hs;
                waddr = idx;
                wdata = '0;
                raddr = hs ? idx + 1'b1 : idx;
            end
            S_ACCUM: begin
                we    = s2_valid;
                raddr = pix_bin;
            end
            default: begin
                we    = s2_valid;
            end
        endcase
    end

    always_ff @(posedge clk_pixel_i) begin
        if (we) mem[waddr] <= wdata;
        rd_data <= mem[raddr];
    end

    always_ff @(posedge clk_pixel_i) begin
        if (reset_i) begin
            state         <= S_CLEAR;
            fv_q          <= 1'b0;
            idx           <= '0;
            pix_cnt       <= '0;
            pixel_count_o <= '0;
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            s3_valid      <= 1'b0;
            s1_bin        <= '0;
            s2_bin        <= '0;
            s3_bin        <= '0;
            s2_val        <= '0;
            s3_val        <= '0;
        end else begin
            state    <= state_nxt;
            fv_q     <= fv_i;
            s1_valid <= pix_valid;
            s1_bin   <= pix_bin;
            s2_valid <= s1_valid;
            s2_bin   <= s1_bin;
            s2_val   <= inc;
            s3_valid <= s2_valid;
            s3_bin   <= s2_bin;
            s3_val   <= s2_val;

            case (state)
                S_CLEAR:   idx <= idx + 1'b1;
                S_READOUT: if (hs) idx <= idx + 1'b1;
                default:   idx <= '0;
            endcase

            if (state == S_IDLE && state_nxt == S_ACCUM)
                pix_cnt <= '0;
            else if (pix_valid && pix_cnt != '1)
                pix_cnt <= pix_cnt + 32'd1;

            if (state == S_DRAIN && pipe_empty)
                pixel_count_o <= pix_cnt;
        end
    end

    assign hist.hist_valid_o = (state == S_READOUT);
    assign hist.hist_bin_o   = (state == S_READOUT) ? idx : '0;
    assign hist.hist_data_o  = (state == S_READOUT) ? rd_data : '0;
    assign hist.hist_last_o  = (state == S_READOUT) && (idx == LAST_BIN);

    assign frame_done_o    = hs && (idx == LAST_BIN);
    assign frame_dropped_o = ~reset_i & fv_rise &
                             ((state == S_CLEAR) || (state == S_DRAIN) || (state == S_READOUT));
    assign busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_pixel_histogram.sv
// Drives two histogram instances (wide and 4-bit saturating counters) with
// the same pixel stream and checks each readout against a reference model.
module tb_pixel_histogram;

    localparam int PIX_W     = 10;
    localparam int BIN_BITS  = 8;
    localparam int NB        = 1 << BIN_BITS;
    localparam int CNT_BIG   = 24;
    localparam int CNT_SMALL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [PIX_W-1:0] pd = '0;
    logic fv = 1'b0, lv = 1'b0, enable = 1'b0, ready = 1'b1;
    bit   rand_ready = 1'b0;

    pixel_histogram_if #(.BIN_BITS(BIN_BITS), .CNT_W(CNT_BIG))   if_big();
    pixel_histogram_if #(.BIN_BITS(BIN_BITS), .CNT_W(CNT_SMALL)) if_small();
    assign if_big.hist_ready_i   = ready;
    assign if_small.hist_ready_i = ready;

    logic        done_b, drop_b, busy_b, done_s, drop_s, busy_s;
    logic [31:0] pc_b, pc_s;

    pixel_histogram #(.PIX_W(PIX_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_BIG)) u_big (
        .clk_pixel_i(clk), .reset_i(reset), .pd_i(pd), .fv_i(fv), .lv_i(lv),
        .enable_i(enable), .hist(if_big), .frame_done_o(done_b),
        .frame_dropped_o(drop_b), .pixel_count_o(pc_b), .busy_o(busy_b)
    );

    pixel_histogram #(.PIX_W(PIX_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_SMALL)) u_small (
        .clk_pixel_i(clk), .reset_i(reset), .pd_i(pd), .fv_i(fv), .lv_i(lv),
        .enable_i(enable), .hist(if_small), .frame_done_o(done_s),
        .frame_dropped_o(drop_s), .pixel_count_o(pc_s), .busy_o(busy_s)
    );

    // ---------------- scoreboard ----------------
    // Entry = {bin[7:0], count[23:0]}; one queue per instance.
    logic [31:0] exp_q0[$], exp_q1[$];
    logic [31:0] pc_q0[$],  pc_q1[$];
    logic [PIX_W-1:0] frame_px[$];
    int tests = 0, fails = 0;
    int done_cnt[2];
    int drop_cnt[2];
    bit stall_pend[2];
    logic [32:0] stall_val[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: count each pixel of the frame into its bin with plain
    // arithmetic, clip to each instance's counter range.
    task automatic expect_frame();
        int h[NB];
        int cap_big, cap_small;
        cap_big   = (1 << CNT_BIG) - 1;
        cap_small = (1 << CNT_SMALL) - 1;
        for (int b = 0; b < NB; b++) h[b] = 0;
        foreach (frame_px[i]) h[int'(frame_px[i]) / (1 << (PIX_W - BIN_BITS))]++;
        for (int b = 0; b < NB; b++) begin
            exp_q0.push_back({b[7:0], 24'(h[b] > cap_big   ? cap_big   : h[b])});
            exp_q1.push_back({b[7:0], 24'(h[b] > cap_small ? cap_small : h[b])});
        end
        pc_q0.push_back(32'(frame_px.size()));
        pc_q1.push_back(32'(frame_px.size()));
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int w, input logic valid, input logic [7:0] bin,
                       input logic [23:0] data, input logic last, input logic done,
                       input logic drop, input logic [31:0] pc);
        logic [31:0] e;
        logic [31:0] epc;
        bit have;
        if (drop) drop_cnt[w]++;
        if (valid && stall_pend[w])
            check($sformatf("stall_hold[%0d]", w), 64'({last, bin, data}), 64'(stall_val[w]));
        stall_pend[w] = 1'b0;
        if (valid && ready) begin
            have = (w == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            if (!have) begin
                tests++; fails++;
                $display("FAIL unexpected_bin[%0d]: got bin %0d data %0d expected none", w, bin, data);
            end else begin
                e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("bin[%0d]", w),  64'(bin),  64'(e[31:24]));
                check($sformatf("data[%0d] bin %0d", w, e[31:24]), 64'(data), 64'(e[23:0]));
                check($sformatf("last[%0d]", w), 64'(last), 64'(e[31:24] == 8'hFF));
                check($sformatf("frame_done[%0d]", w), 64'(done), 64'(e[31:24] == 8'hFF));
                if (e[31:24] == 8'hFF) begin
                    have = (w == 0) ? (pc_q0.size() > 0) : (pc_q1.size() > 0);
                    epc = 32'hDEADBEEF;
                    if (have) epc = (w == 0) ? pc_q0.pop_front() : pc_q1.pop_front();
                    check($sformatf("pixel_count[%0d]", w), 64'(pc), 64'(epc));
                    done_cnt[w]++;
                end
            end
        end else begin
            if (valid) begin
                stall_pend[w] = 1'b1;
                stall_val[w]  = {last, bin, data};
            end
            if (done) begin
                tests++; fails++;
                $display("FAIL spurious_done[%0d]: got 1 expected 0", w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_pend[0] = 1'b0;
            stall_pend[1] = 1'b0;
        end else begin
            mon(0, if_big.hist_valid_o, if_big.hist_bin_o, if_big.hist_data_o,
                if_big.hist_last_o, done_b, drop_b, pc_b);
            mon(1, if_small.hist_valid_o, if_small.hist_bin_o, {20'b0, if_small.hist_data_o},
                if_small.hist_last_o, done_s, drop_s, pc_s);
        end
    end

    // ---------------- driver tasks ----------------
    initial forever begin
        @(posedge clk); #1;
        ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        int c;
        reset = 1'b1; fv = 1'b0; lv = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", 64'(if_big.hist_valid_o), 64'd0);
        check("rst_data",  64'(if_big.hist_data_o),  64'd0);
        check("rst_done",  64'(done_b), 64'd0);
        check("rst_drop",  64'(drop_b), 64'd0);
        check("rst_pcount", 64'(pc_b), 64'd0);
        step();
        reset = 1'b0;
        c = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy_b) break;
            c++;
        end
        check("clear_busy_cycles", 64'(c), 64'd256);
    endtask

    // Sends frame_px as lines of ppl pixels. The last pixel's cycle is
    // immediately followed by fv falling, so the final sample is exercised.
    task automatic send_frame(input int ppl, input bit captured);
        int n;
        n = frame_px.size();
        lv = 1'b1; pd = PIX_W'($urandom); step();   // lv without fv: ignored
        lv = 1'b0; step();
        if (captured) expect_frame();
        fv = 1'b1; step(); step();
        for (int i = 0; i < n; i++) begin
            lv = 1'b1; pd = frame_px[i]; step();
            if ((i + 1) % ppl == 0 && i != n - 1) begin
                lv = 1'b0; pd = PIX_W'($urandom); step(); step();
            end
        end
        lv = 1'b0; fv = 1'b0; step();
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (done_cnt[0] >= target && done_cnt[1] >= target) break;
            step();
        end
        if (i == 4000) begin
            tests++; fails++;
            $display("FAIL wait_done: got %0d/%0d frames expected %0d", done_cnt[0], done_cnt[1], target);
        end
        step(); step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nf, d0, d1, k;
        logic [PIX_W-1:0] saved[$];
        nf = 0;
        do_reset();
        enable = 1'b1;

        // 4 lines x 8 pixels of full scale
        frame_px.delete();
        repeat (32) frame_px.push_back(10'h3FF);
        send_frame(8, 1'b1); wait_done(++nf);

        // back-to-back same-bin pixels and a bin 2 ahead
        frame_px = '{10'h004, 10'h004, 10'h004, 10'h008, 10'h004};
        send_frame(5, 1'b1); wait_done(++nf);

        // narrow-range random pixels, random ready, sent twice
        rand_ready = 1'b1;
        frame_px.delete();
        repeat (40) frame_px.push_back(PIX_W'($urandom_range(0, 15)));
        saved = frame_px;
        send_frame(10, 1'b1); wait_done(++nf);
        frame_px = saved;
        send_frame(10, 1'b1); wait_done(++nf);
        frame_px.delete();
        repeat (60) frame_px.push_back(PIX_W'($urandom));
        send_frame(12, 1'b1); wait_done(++nf);

        // frame start during readout is dropped
        frame_px.delete();
        repeat (16) frame_px.push_back(PIX_W'($urandom_range(0, 63)));
        send_frame(8, 1'b1);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if_big.hist_valid_o) break;
        end
        step();
        check("readout_started", 64'(k < 200), 64'd1);
        d0 = drop_cnt[0]; d1 = drop_cnt[1];
        frame_px.delete();
        repeat (8) frame_px.push_back(10'h200);
        send_frame(4, 1'b0);
        wait_done(++nf);
        check("dropped_pulses[0]", 64'(drop_cnt[0] - d0), 64'd1);
        check("dropped_pulses[1]", 64'(drop_cnt[1] - d1), 64'd1);
        frame_px.delete();
        repeat (12) frame_px.push_back(PIX_W'($urandom_range(512, 1023)));
        send_frame(6, 1'b1); wait_done(++nf);

        // frame start with enable low: ignored, no pulse
        enable = 1'b0;
        d0 = drop_cnt[0];
        frame_px = '{10'h100, 10'h100, 10'h104};
        send_frame(3, 1'b0);
        repeat (300) step();
        check("disabled_no_drop", 64'(drop_cnt[0] - d0), 64'd0);
        enable = 1'b1;

        // counter saturation on the narrow instance
        rand_ready = 1'b0;
        frame_px.delete();
        repeat (20) frame_px.push_back(PIX_W'($urandom_range(0, 3)));
        send_frame(20, 1'b1); wait_done(++nf);

        // reset in the middle of accumulation, then a clean frame
        fv = 1'b1; step(); step();
        repeat (5) begin lv = 1'b1; pd = 10'h01C; step(); end
        do_reset();
        frame_px.delete();
        repeat (10) frame_px.push_back(10'h000);
        send_frame(10, 1'b1); wait_done(++nf);

        check("exp_q0_empty", 64'(exp_q0.size()), 64'd0);
        check("exp_q1_empty", 64'(exp_q1.size()), 64'd0);
        check("pc_q_empty",   64'(pc_q0.size() + pc_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
